// File: rtl/nes_pad_poll_scheduler.sv
// Polls two NES-style serial gamepads sharing one latch/clock pair, from a
// periodic timer or on demand, and publishes both button bytes with a valid/changed strobe.
module nes_pad_poll_scheduler #(
   parameter int LATCH_CYCLES       = 324,
   parameter int HALF_BIT_CYCLES    = 162,
   parameter int POLL_PERIOD_CYCLES = 225000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_auto_en,
   input  logic       i_poll_req,
   input  logic       i_serial_data0,
   input  logic       i_serial_data1,
   output logic       o_data_latch,
   output logic       o_data_clock,
   output logic [7:0] o_pad0_state,
   output logic [7:0] o_pad1_state,
   output logic       o_valid,
   output logic       o_changed,
   output logic       o_busy
);

   localparam int MAX_PHASE = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
   localparam int CW = $clog2(MAX_PHASE + 1);
   localparam int TW = (POLL_PERIOD_CYCLES > 1) ? $clog2(POLL_PERIOD_CYCLES) : 1;

   localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CYCLES - 1);
   localparam logic [CW-1:0] HALF_LOAD  = CW'(HALF_BIT_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_PERIOD_CYCLES - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LATCH = 3'd1;
   localparam logic [2:0] ST_LOW   = 3'd2;
   localparam logic [2:0] ST_HIGH  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   logic [2:0]    state_q,   state_d;
   logic [CW-1:0] phase_q,   phase_d;
   logic [2:0]    bit_q,     bit_d;
   logic          pending_q, pending_d;
   logic [TW-1:0] timer_q,   timer_d;
   logic [7:0]    sr0_q,     sr0_d;
   logic [7:0]    sr1_q,     sr1_d;
   logic          latch_q,   latch_d;
   logic          clock_q,   clock_d;
   logic [7:0]    pad0_q,    pad0_d;
   logic [7:0]    pad1_q,    pad1_d;
   logic          valid_q,   valid_d;
   logic          changed_q, changed_d;
   logic          busy_q,    busy_d;
   logic          tick;
   logic          trig;

   always_comb begin
      tick = i_auto_en && (timer_q == TIMER_LAST);
      trig = tick || i_poll_req;

      if (!i_auto_en || (timer_q == TIMER_LAST)) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TW'(1);
      end

      state_d   = state_q;
      phase_d   = phase_q;
      bit_d     = bit_q;
      pending_d = pending_q;
      sr0_d     = sr0_q;
      sr1_d     = sr1_q;

      // Triggers arriving mid-poll collapse into a single pending poll.
      if (trig && (state_q != ST_IDLE)) begin
         pending_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (trig) begin
               state_d = ST_LATCH;
               phase_d = LATCH_LOAD;
            end
         end
         ST_LATCH: begin
            if (phase_q == '0) begin
               state_d = ST_LOW;
               phase_d = HALF_LOAD;
               bit_d   = 3'd0;
            end else begin
               phase_d = phase_q - CW'(1);
            end
         end
         ST_LOW: begin
            if (phase_q == '0) begin
               sr0_d   = {~i_serial_data0, sr0_q[7:1]};
               sr1_d   = {~i_serial_data1, sr1_q[7:1]};
               state_d = ST_HIGH;
               phase_d = HALF_LOAD;
            end else begin
               phase_d = phase_q - CW'(1);
            end
         end
         ST_HIGH: begin
            if (phase_q == '0) begin
               if (bit_q == 3'd7) begin
                  state_d = ST_DONE;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  state_d = ST_LOW;
                  phase_d = HALF_LOAD;
               end
            end else begin
               phase_d = phase_q - CW'(1);
            end
         end
         ST_DONE: begin
            pending_d = 1'b0;
            if (pending_q || trig) begin
               state_d = ST_LATCH;
               phase_d = LATCH_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they line up with it.
      latch_d   = (state_d == ST_LATCH);
      clock_d   = (state_d == ST_HIGH);
      busy_d    = (state_d != ST_IDLE);
      valid_d   = (state_d == ST_DONE);
      pad0_d    = pad0_q;
      pad1_d    = pad1_q;
      changed_d = 1'b0;
      if (state_d == ST_DONE) begin
         pad0_d    = sr0_q;
         pad1_d    = sr1_q;
         changed_d = (sr0_q != pad0_q) || (sr1_q != pad1_q);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         phase_q   <= '0;
         bit_q     <= '0;
         pending_q <= 1'b0;
         timer_q   <= '0;
         sr0_q     <= '0;
         sr1_q     <= '0;
         latch_q   <= 1'b0;
         clock_q   <= 1'b0;
         pad0_q    <= '0;
         pad1_q    <= '0;
         valid_q   <= 1'b0;
         changed_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         pending_q <= pending_d;
         timer_q   <= timer_d;
         sr0_q     <= sr0_d;
         sr1_q     <= sr1_d;
         latch_q   <= latch_d;
         clock_q   <= clock_d;
         pad0_q    <= pad0_d;
         pad1_q    <= pad1_d;
         valid_q   <= valid_d;
         changed_q <= changed_d;
         busy_q    <= busy_d;
      end
   end

   assign o_data_latch = latch_q;
   assign o_data_clock = clock_q;
   assign o_pad0_state = pad0_q;
   assign o_pad1_state = pad1_q;
   assign o_valid      = valid_q;
   assign o_changed    = changed_q;
   assign o_busy       = busy_q;

endmodule

// File: tb/tb_nes_pad_poll_scheduler.sv
// Bench for nes_pad_poll_scheduler: two behavioural pads feed the data lines and a
// scoreboard pairs every latch event with the o_valid strobe it must produce.
module tb_nes_pad_poll_scheduler;

   localparam int LC = 4;
   localparam int HC = 2;
   localparam int PC = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       auto_en = 1'b0;
   logic       poll_req = 1'b0;
   logic       s0, s1;
   logic       o_data_latch, o_data_clock, o_valid, o_changed, o_busy;
   logic [7:0] o_pad0_state, o_pad1_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic rst_at_edge = 1'b1;

   // Pad model: buttons are captured on latch rise and shifted out on each clock rise.
   logic [7:0] btn0 = 8'h00, btn1 = 8'h00;
   logic [7:0] sh0 = 8'h00, sh1 = 8'h00;
   logic [7:0] prev0 = 8'h00, prev1 = 8'h00;
   logic [7:0] last0 = 8'h00, last1 = 8'h00;
   logic [16:0] exp_q[$];

   nes_pad_poll_scheduler #(
      .LATCH_CYCLES(LC),
      .HALF_BIT_CYCLES(HC),
      .POLL_PERIOD_CYCLES(PC)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_auto_en(auto_en),
      .i_poll_req(poll_req),
      .i_serial_data0(s0),
      .i_serial_data1(s1),
      .o_data_latch(o_data_latch),
      .o_data_clock(o_data_clock),
      .o_pad0_state(o_pad0_state),
      .o_pad1_state(o_pad1_state),
      .o_valid(o_valid),
      .o_changed(o_changed),
      .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      rst_at_edge <= rst;
   end

   assign s0 = ~sh0[0];
   assign s1 = ~sh1[0];

   always @(posedge o_data_latch) begin
      sh0 = btn0;
      sh1 = btn1;
      exp_q.push_back({(btn0 != prev0) || (btn1 != prev1), btn0, btn1});
      prev0 = btn0;
      prev1 = btn1;
   end

   always @(posedge o_data_clock) begin
      sh0 = sh0 >> 1;
      sh1 = sh1 >> 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every o_valid and polices output hold.
   always @(negedge clk) begin
      logic [16:0] e;
      if (o_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL valid_without_poll: o_valid seen with no outstanding poll (cycle %0d)", cyc);
         end else begin
            e = exp_q.pop_front();
            check("pad0_state", {24'h0, o_pad0_state}, {24'h0, e[15:8]});
            check("pad1_state", {24'h0, o_pad1_state}, {24'h0, e[7:0]});
            check("changed", {31'h0, o_changed}, {31'h0, e[16]});
            check("busy_at_valid", {31'h0, o_busy}, 32'h1);
         end
      end else if (rst_at_edge !== 1'b1) begin
         check("hold_state", {16'h0, o_pad0_state, o_pad1_state}, {16'h0, last0, last1});
      end
      last0 = o_pad0_state;
      last1 = o_pad1_state;
   end

   task automatic pulse_req();
      @(posedge clk);
      #1 poll_req = 1'b1;
      @(posedge clk);
      #1 poll_req = 1'b0;
   endtask

   task automatic wait_valid(output int c, input int budget, input string name);
      c = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (o_valid === 1'b1) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) begin
         checks++;
         errors++;
         $display("FAIL %s: no o_valid within %0d cycles", name, budget);
      end
   endtask

   task automatic wait_latch(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (o_data_latch === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s: latch never rose", name);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int va, vb, vc, vd, ve, hits, rises;
      logic prev_clk;
      logic [3:0] expv;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_ctrl", {28'h0, o_data_latch, o_data_clock, o_busy, o_valid}, 32'h0);
      check("reset_pads", {16'h0, o_pad0_state, o_pad1_state}, 32'h0);
      check("reset_changed", {31'h0, o_changed}, 32'h0);

      // Exact waveform after a single request issued in cycle t.
      btn0 = 8'h12;
      btn1 = 8'h34;
      @(posedge clk);
      #1 poll_req = 1'b1;
      @(posedge clk);
      #1 poll_req = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         expv[3] = (k >= 1 && k <= 4);
         expv[2] = (k >= 5 && k <= 36 && ((k - 5) % 4) >= 2);
         expv[1] = (k <= 37);
         expv[0] = (k == 37);
         check($sformatf("wave_t+%0d", k), {28'h0, o_data_latch, o_data_clock, o_busy, o_valid},
               {28'h0, expv});
      end

      // A, Start, Right on pad 0; pad 1 idle.
      btn0 = 8'h89;
      btn1 = 8'h00;
      pulse_req();
      wait_valid(va, 100, "scenario2");
      check("s2_pad0", {24'h0, o_pad0_state}, 32'h89);
      check("s2_pad1", {24'h0, o_pad1_state}, 32'h00);
      check("s2_changed", {31'h0, o_changed}, 32'h1);
      pulse_req();
      wait_valid(va, 100, "scenario3");
      check("s3_pad0", {24'h0, o_pad0_state}, 32'h89);
      check("s3_changed", {31'h0, o_changed}, 32'h0);

      // Idle with no triggers.
      hits = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (o_data_latch || o_data_clock || o_valid || o_busy) hits++;
      end
      check("idle_quiet", hits, 0);

      // Periodic polling.
      btn0 = 8'($urandom);
      btn1 = 8'($urandom);
      @(posedge clk);
      #1 auto_en = 1'b1;
      wait_valid(va, 300, "auto_first");
      wait_valid(vb, 150, "auto_second");
      check("auto_period", vb - va, PC);

      wait_latch("extra1_latch");
      btn0 = 8'($urandom);
      pulse_req();
      wait_valid(va, 150, "extra1_a");
      wait_valid(vb, 150, "extra1_b");
      check("extra1_gap", vb - va, 37);
      wait_valid(vc, 150, "extra1_c");
      check("extra1_auto", vc - va, PC);

      wait_latch("extra3_latch");
      btn1 = 8'($urandom);
      pulse_req();
      pulse_req();
      pulse_req();
      wait_valid(va, 150, "extra3_a");
      wait_valid(vb, 150, "extra3_b");
      check("extra3_gap", vb - va, 37);
      wait_valid(vc, 150, "extra3_c");
      check("extra3_single", vc - va, PC);

      // Request coinciding with the auto tick yields a single poll.
      repeat (63) @(posedge clk);
      #1 poll_req = 1'b1;
      @(posedge clk);
      #1 poll_req = 1'b0;
      wait_valid(vd, 150, "coincide_a");
      check("coincide_timing", vd - vc, PC);
      wait_valid(ve, 150, "coincide_b");
      check("coincide_single", ve - vd, PC);
      @(posedge clk);
      #1 auto_en = 1'b0;
      repeat (50) @(posedge clk);

      // Reset during the high phase of bit 4.
      btn0 = 8'hA5;
      btn1 = 8'h3C;
      pulse_req();
      wait_valid(va, 100, "pre_reset");
      pulse_req();
      rises = 0;
      prev_clk = 1'b0;
      for (int i = 0; i < 100 && rises < 5; i++) begin
         @(negedge clk);
         if (o_data_clock && !prev_clk) rises++;
         prev_clk = o_data_clock;
      end
      check("reached_bit4", rises, 5);
      rst = 1'b1;
      exp_q.delete();
      prev0 = 8'h00;
      prev1 = 8'h00;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midreset_ctrl", {28'h0, o_data_latch, o_data_clock, o_busy, o_valid}, 32'h0);
      check("midreset_pads", {16'h0, o_pad0_state, o_pad1_state}, 32'h0);
      hits = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (o_valid || o_busy) hits++;
      end
      check("midreset_quiet", hits, 0);

      // Randomized requests, including ones landing mid-poll.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) != 0) btn0 = 8'($urandom);
         if ($urandom_range(0, 3) != 0) btn1 = 8'($urandom);
         pulse_req();
         repeat ($urandom_range(0, 60)) @(posedge clk);
      end
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      check("drain_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nes_pad_poll_scheduler.md
Name: nes_pad_poll_scheduler

Overview:
Sequences polling of two NES-style serial gamepads that share one latch line and one clock line, each with its own serial data line.
It issues polls from a periodic timer or from an on-demand request, and generates the latch and clock waveforms with exact cycle counts.
It deserializes both pads in parallel and publishes registered button bytes with a valid/changed strobe.
It sits between the pad connector pins and the input-register logic ($4016/$4017 emulation, OSD).

Parameters:
LATCH_CYCLES, 324, latch high time in i_clk cycles (12 us at 27 MHz)
HALF_BIT_CYCLES, 162, length of each clock-low and clock-high phase in i_clk cycles (6 us)
POLL_PERIOD_CYCLES, 225000, auto-poll period in i_clk cycles (120 Hz at 27 MHz); must be > LATCH_CYCLES + 16*HALF_BIT_CYCLES

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous active-high reset
i_auto_en  input  1  enable periodic polling
i_poll_req  input  1  single-cycle on-demand poll request
i_serial_data0  input  1  pad 0 data, active-low (0 = pressed)
i_serial_data1  input  1  pad 1 data, active-low
o_data_latch  output  1  shared latch to both pads
o_data_clock  output  1  shared clock to both pads
o_pad0_state  output  8  pad 0 buttons, active-high; [7:0] = Right Left Down Up Start Select B A
o_pad1_state  output  8  pad 1 buttons, same order
o_valid  output  1  one-cycle pulse when both state bytes have been updated
o_changed  output  1  asserted with o_valid when either byte differs from its previous value; 0 otherwise
o_busy  output  1  high from the first latch cycle through the o_valid cycle

Behaviour:
- Clock: i_clk only. Reset: synchronous, active-high. All outputs are registered.
- Reset values:
  - All outputs 0; FSM in IDLE.
  - Period timer 0; pending flag 0; shift registers 0.
- Reset mid-poll: at the next edge, latch and clock drop to 0, the FSM returns to IDLE, and the partial data is discarded (state bytes cleared).
- Period timer:
  - Free-runs 0..POLL_PERIOD_CYCLES-1 and wraps.
  - Produces a tick on the terminal count when i_auto_en=1.
  - Holds at 0 while i_auto_en=0.
- Trigger: trig = tick | i_poll_req.
  - In IDLE: trig moves to LATCH on the next edge, so o_data_latch=1 in cycle t+1 after a request in cycle t.
  - Not in IDLE: trig sets the one-deep pending flag. Further triggers while pending is set are absorbed.
  - On entering IDLE from DONE with pending=1: go directly to LATCH next cycle and clear pending.
- FSM states:
  - IDLE: latch=0, clock=0.
  - LATCH: latch=1 for exactly LATCH_CYCLES cycles, then LOW with bit index k=0.
  - LOW: latch=0, clock=0 for HALF_BIT_CYCLES cycles.
    - On the last LOW cycle, sample both data lines.
    - Shift the inverted bit in LSB-first: sr <= {~din, sr[7:1]}, so bit 0 = A after 8 samples.
    - Then go to HIGH.
  - HIGH: clock=1 for HALF_BIT_CYCLES cycles.
    - At the end, if k=7 go to DONE; otherwise k<=k+1 and go to LOW.
  - DONE: one cycle.
    - o_pad0_state/o_pad1_state <= shift registers.
    - o_valid=1; o_changed=(new != old) for either pad.
    - Then IDLE (or LATCH if pending).
- Totals per poll: 8 samples, 8 clock pulses, LATCH_CYCLES + 16*HALF_BIT_CYCLES active cycles, then one DONE cycle.
- o_busy=1 in LATCH, LOW, HIGH and DONE.
- Output hold: state bytes change only in DONE and on reset; they are stable at all other times.
- Phase counter: counts down from LATCH_CYCLES-1 or HALF_BIT_CYCLES-1 to 0; its width must hold max(LATCH_CYCLES, HALF_BIT_CYCLES).
- Simultaneous tick and i_poll_req in IDLE: one poll only; pending is not set.
- Unplugged pad: the line is pulled high, so the pad reads all 0 (no buttons); no special handling.

Test Plan:
Common setup: LATCH_CYCLES=4, HALF_BIT_CYCLES=2, POLL_PERIOD_CYCLES=100.
1. Reset, then i_poll_req pulse at cycle t.
   - Expected waveform: latch high t+1..t+4, then 8× (clock low 2, clock high 2).
   - Expected strobes: o_valid at t+37; o_busy high t+1..t+37.
2. Pad 0 drives A, Start, Right pressed (serial low at samples 0, 3, 7); pad 1 idle high.
   - Expected: o_pad0_state=8'h89, o_pad1_state=8'h00, o_changed=1.
3. Repeat scenario 2's stimulus.
   - Expected: o_valid=1, o_changed=0, values unchanged.
4. i_auto_en=1, no requests: o_valid pulses every 100 cycles.
   - Inject an i_poll_req mid-poll: exactly one extra poll follows immediately after DONE.
   - Inject three requests mid-poll: still exactly one extra poll.
5. Assert i_rst during HIGH of bit 4.
   - Expected next cycle: latch=0, clock=0, o_busy=0, both state bytes 0x00.
   - No o_valid until a new trigger.
6. i_auto_en=0, no requests for 1000 cycles: latch and clock stay 0, no o_valid.
